lane_remap_ctrl: RTL
====================

Name: lane_remap_ctrl

Overview:
- Configuration controller for the redundancy lane-steering muxes: maps NUM_OUT logical outputs onto NUM_LANES = NUM_OUT+NUM_SPARE physical lanes, skipping faulty lanes.
- On a start pulse it latches a fault mask and scans one physical lane per cycle, building a shadow select table.
- On success it commits the table atomically to the per-output N-to-1 mux selects; on failure the live selects are left untouched.

Parameters:
- NUM_OUT, 6, number of logical outputs, each driven by one NUM_LANES-to-1 mux.
- NUM_SPARE, 2, number of spare physical lanes; NUM_LANES must be ≤ 64.
- SEL_W, $clog2(NUM_OUT+NUM_SPARE), derived select width (3 at defaults, which matches an 8-to-1 mux).
- CNT_W, $clog2(NUM_OUT+NUM_SPARE+1), derived fault-count width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to recompute the mapping.
- fault_mask  input  NUM_LANES  bit p=1 means physical lane p is faulty; sampled only on an accepted start.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when a scan completes.
- fail  output  1  last scan found fewer than NUM_OUT good lanes.
- map_valid  output  1  sel_flat holds a committed, fault-free mapping.
- fault_count  output  CNT_W  popcount of the last latched mask.
- sel_flat  output  NUM_OUT*SEL_W  select for output i occupies bits [i*SEL_W +: SEL_W].

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - State IDLE; busy=0, done=0, fail=0, map_valid=0, fault_count=0.
  - sel_flat is the identity map (output i selects lane i).
  - Shadow table and counters are cleared.
- FSM has two states, IDLE and SCAN.
- IDLE:
  - start=1 in cycle T latches fault_mask, clears the scan index p, output index k, fault counter and shadow table, then enters SCAN.
- SCAN (cycles T+1 .. T+NUM_LANES, busy=1, one lane per cycle):
  - Let f = latched_mask[p].
  - If f=0 and k<NUM_OUT: shadow[k] <= p, k <= k+1.
  - If f=1: fault counter <= counter+1.
  - p <= p+1.
  - After lane NUM_LANES-1, go to IDLE.
- Completion, registered at cycle T+NUM_LANES+1:
  - done=1 for exactly that cycle; busy=0; fault_count is updated.
  - Success (k==NUM_OUT, equivalently count ≤ NUM_SPARE): sel_flat <= shadow, map_valid=1, fail=0.
  - Failure: sel_flat holds its previous value, map_valid=0, fail=1.
- Fixed latency: NUM_LANES+1 cycles from start to done, independent of the mask. The scan never terminates early.
- start while busy=1 is ignored: no restart and no queuing. start in the done cycle is accepted.
- fault_mask changes during SCAN have no effect.
- Lane order is ascending: lowest-index good lanes go to the lowest outputs. Surplus good lanes stay unused.
- sel_flat changes only at reset or on a successful commit, never mid-scan. Downstream muxes therefore never see a partial table.
- reset during SCAN: the scan is abandoned immediately, outputs return to reset values, and no done pulse is generated.
- fail and map_valid hold until the next completion or reset.

Decomposition:
- Shared package lane_remap_pkg holds:
  - State enum: IDLE, SCAN.
  - Default constants NUM_OUT_DEF=6 and NUM_SPARE_DEF=2.
  - Select-slice helper function sel_of(flat, i).
- The steering datapath is not part of this block.
- One natural sub-module, lane_remap_scan_cnt: holds p, k and the fault counter with the increment/assign logic. The FSM and commit registers stay in the top level.

Test Plan:
- Reset release, no start → sel_flat = identity (0,1,2,3,4,5), map_valid=0, busy=0, done=0.
- start with mask 8'b00000000 at T → busy on T+1..T+8; done at T+9; sel=(0,1,2,3,4,5); map_valid=1; fault_count=0; fail=0.
- start with mask 8'b00000100 → sel=(0,1,3,4,5,6), fault_count=1, map_valid=1. Then mask 8'b11000000 → sel=(0,1,2,3,4,5), fault_count=2.
- After a valid map (0,1,3,4,5,6), start with mask 8'b00010101 → done at T+9, fail=1, map_valid=0, fault_count=3, sel_flat unchanged at (0,1,3,4,5,6).
- start pulses at T+3 and T+5 during a scan → ignored, done only at T+9. start in the done cycle → new scan completes 9 cycles later.
- reset asserted at T+4 mid-scan → next cycle busy=0, no done pulse, sel_flat identity, map_valid=0. Then a fresh start completes normally.

Source files
------------

// File: rtl/lane_remap_pkg.sv
// Shared types and helpers for the lane remap controller.
// Select slices are packed lowest output first.
package lane_remap_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int NUM_OUT_DEF   = 6;
  localparam int NUM_SPARE_DEF = 2;
  localparam int MAX_LANES     = 64;
  localparam int MAX_SEL_W     = 6;
  localparam int MAX_FLAT_W    = MAX_LANES * MAX_SEL_W;
  localparam int SEL_W_DEF     =
    $clog2(NUM_OUT_DEF + NUM_SPARE_DEF);

  // Callers zero-extend their flat vector to MAX_FLAT_W.
  function automatic logic [MAX_SEL_W-1:0] sel_of(
    input logic [MAX_FLAT_W-1:0] flat,
    input int                    i,
    input int                    w = SEL_W_DEF
  );
    logic [MAX_FLAT_W-1:0] s;
    logic [MAX_SEL_W-1:0]  m;
    s = flat >> (i * w);
    m = MAX_SEL_W'((1 << w) - 1);
    return MAX_SEL_W'(s) & m;
  endfunction

endpackage

// File: rtl/lane_remap_scan_cnt.sv
// Scan counters: lane index p, output index k, fault count.
// Next values are exported so the commit can see the final lane.
module lane_remap_scan_cnt
  import lane_remap_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int SEL_W   = 3,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bad,
  output logic [SEL_W-1:0] p_q,
  output logic [CNT_W-1:0] k_q,
  output logic [CNT_W-1:0] k_nxt,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [SEL_W-1:0] p_d;
  logic [CNT_W-1:0] k_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    p_d   = p_q;
    k_d   = k_q;
    cnt_d = cnt_q;
    if (clr) begin
      p_d   = '0;
      k_d   = '0;
      cnt_d = '0;
    end else if (en) begin
      p_d = p_q + 1'b1;
      if (!bad && k_q < CNT_W'(NUM_OUT))
        k_d = k_q + 1'b1;
      if (bad)
        cnt_d = cnt_q + 1'b1;
    end
  end

  assign k_nxt   = k_d;
  assign cnt_nxt = cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q   <= '0;
      k_q   <= '0;
      cnt_q <= '0;
    end else begin
      p_q   <= p_d;
      k_q   <= k_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lane_remap_ctrl.sv
// Lane remap controller: scans a latched fault mask and commits
// a complete select table only when enough good lanes exist.
module lane_remap_ctrl
  import lane_remap_pkg::*;
#(
  parameter int NUM_OUT   = NUM_OUT_DEF,
  parameter int NUM_SPARE = NUM_SPARE_DEF,
  parameter int NUM_LANES = NUM_OUT + NUM_SPARE,
  parameter int SEL_W     = $clog2(NUM_OUT + NUM_SPARE),
  parameter int CNT_W     = $clog2(NUM_OUT + NUM_SPARE + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_LANES-1:0]     fault_mask,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic                     map_valid,
  output logic [CNT_W-1:0]         fault_count,
  output logic [NUM_OUT*SEL_W-1:0] sel_flat
);

  localparam int FLAT_W = NUM_OUT * SEL_W;

  function automatic logic [FLAT_W-1:0] ident();
    logic [FLAT_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_OUT; i++)
      f[i*SEL_W +: SEL_W] = SEL_W'(i);
    return f;
  endfunction

  state_e state_q, state_d;

  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [FLAT_W-1:0]    shadow_q, shadow_d;
  logic [FLAT_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 valid_q, valid_d;

  logic             accept;
  logic             scan_en;
  logic             last;
  logic             lane_bad;
  logic [SEL_W-1:0] p_q;
  logic [CNT_W-1:0] k_q;
  logic [CNT_W-1:0] k_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign accept   = (state_q == IDLE) && start;
  assign scan_en  = (state_q == SCAN);
  assign lane_bad = mask_q[p_q];
  assign last     = scan_en &&
                    (p_q == SEL_W'(NUM_LANES - 1));

  lane_remap_scan_cnt #(
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (scan_en),
    .bad     (lane_bad),
    .p_q     (p_q),
    .k_q     (k_q),
    .k_nxt   (k_nxt),
    .cnt_nxt (cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
  end

  always_comb begin
    mask_d   = accept ? fault_mask : mask_q;
    shadow_d = shadow_q;
    if (accept) begin
      shadow_d = '0;
    end else if (scan_en && !lane_bad &&
                 k_q < CNT_W'(NUM_OUT)) begin
      for (int i = 0; i < NUM_OUT; i++)
        if (k_q == CNT_W'(i))
          shadow_d[i*SEL_W +: SEL_W] = p_q;
    end
  end

  // Commit sees the next-state shadow so the last lane counts.
  always_comb begin
    done_d  = last;
    fail_d  = fail_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;
    sel_d   = sel_q;
    if (last) begin
      fcnt_d = cnt_nxt;
      if (k_nxt == CNT_W'(NUM_OUT)) begin
        sel_d   = shadow_d;
        valid_d = 1'b1;
        fail_d  = 1'b0;
      end else begin
        valid_d = 1'b0;
        fail_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q   <= '0;
      shadow_q <= '0;
      sel_q    <= ident();
      fcnt_q   <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      fcnt_q   <= fcnt_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      valid_q  <= valid_d;
    end
  end

  assign done        = done_q;
  assign fail        = fail_q;
  assign map_valid   = valid_q;
  assign fault_count = fcnt_q;
  assign sel_flat    = sel_q;

endmodule
